// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
//   state_t    : fill controller states (IDLE, FILL)
//   ob_bits    : byte-offset width of a line   = log2(LINE_WORDS*4)
//   ib_bits    : set-index width               = log2(SETS)
//   tag_bits   : tag width                     = 32 - ob_bits - ib_bits
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int ob_bits(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int ib_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int line_words);
    return 32 - ob_bits(line_words) - ib_bits(sets);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit and tag, line data storage and the tag
// compare for the current lookup.
//   clk, rst              : clock, synchronous active-high reset
//   clear_all             : invalidate every set next edge (flush)
//   rd_index/word/tag     : lookup address fields
//   hit, line_valid       : tag match at rd_index, valid bit at rd_index
//   rd_data               : word at {rd_index, rd_word} (combinational)
//   wr_en/index/word/data : fill write port
//   wr_first, wr_last     : first / last word of a fill (invalidate / validate)
//   wr_tag                : tag recorded when the last word is written
module icache_way
  import icache_pkg::*;
#(
  parameter  int SETS       = 16,
  parameter  int LINE_WORDS = 16,
  localparam int IB         = ib_bits(SETS),
  localparam int WB         = $clog2(LINE_WORDS),
  localparam int TW         = tag_bits(SETS, LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_all,
  input  logic [IB-1:0] rd_index,
  input  logic [WB-1:0] rd_word,
  input  logic [TW-1:0] rd_tag,
  output logic          hit,
  output logic          line_valid,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IB-1:0] wr_index,
  input  logic [WB-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic          wr_first,
  input  logic          wr_last,
  input  logic [TW-1:0] wr_tag
);

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS*LINE_WORDS];

  // A line being refilled is invalid from its first word until its last, so
  // a partially written line can never hit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    if (rst || clear_all) begin
      valid <= '0;
    end else if (wr_en && wr_first) begin
      valid[wr_index] <= 1'b0;
    end else if (wr_en && wr_last) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, and this keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (wr_en && wr_last) begin
      tag_mem[wr_index] <= wr_tag;
    end
    if (wr_en) begin
      data_mem[{wr_index, wr_word}] <= wr_data;
    end
  end

  assign line_valid = valid[rd_index];
  assign hit        = line_valid && (tag_mem[rd_index] == rd_tag);
  assign rd_data    = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative (1- or 2-way) read-only instruction cache with a
// zero-latency hit path and a single-line refill engine on a simple bus.
//   clk, rst            : clock, synchronous active-high reset
//   rd_addr, rd_req     : core fetch byte address (bits [1:0] ignored), request
//   flush               : one-cycle pulse invalidating every line
//   rd_wait, rd_data    : fetch stall, fetched word (valid when !rd_wait)
//   bus_req, bus_ack    : bus request / grant
//   bus_addr, bus_rd    : word-aligned read address, read strobe
//   bus_rdata, bus_ready: read data, data-valid strobe
//   bus_wr, bus_wdata   : unused write side, tied low
module icache_assoc
  import icache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 16,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_addr,
  input  logic        rd_req,
  input  logic        flush,
  output logic        rd_wait,
  output logic [31:0] rd_data,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [31:0] bus_wdata
);

  localparam int OB = ob_bits(LINE_WORDS);
  localparam int IB = ib_bits(SETS);
  localparam int WB = OB - 2;
  localparam int TW = tag_bits(SETS, LINE_WORDS);
  localparam int LW = 32 - OB;  // line address width (tag + index)

  // Lookup address fields.
  logic [TW-1:0] rd_tag;
  logic [IB-1:0] rd_index;
  logic [WB-1:0] rd_word;
  logic          unused_addr_bits;

  assign rd_tag           = rd_addr[31 -: TW];
  assign rd_index         = rd_addr[OB +: IB];
  assign rd_word          = rd_addr[2 +: WB];
  assign unused_addr_bits = ^rd_addr[1:0];

  // Controller state.
  state_t          state, state_nx;
  logic [WB-1:0]   fill_cnt;
  logic [LW-1:0]   fill_line;
  logic            fill_way;
  logic [SETS-1:0] lru;  // per set: index of the least recently used way

  logic [IB-1:0] fill_index;
  logic [TW-1:0] fill_tag;
  logic          fill_we, fill_first, fill_last;

  assign fill_index = fill_line[IB-1:0];
  assign fill_tag   = fill_line[LW-1:IB];
  assign fill_first = (fill_cnt == '0);
  assign fill_last  = (fill_cnt == WB'(LINE_WORDS - 1));
  // An aborting cycle (flush or reset) must not advance or complete a fill.
  assign fill_we    = (state == FILL) && bus_ack && bus_ready && !flush && !rst;

  // Per-way results; an absent second way never hits and looks valid so it
  // is never picked as a victim.
  logic [1:0]  way_hit, way_valid;
  logic [31:0] way_data [2];

  for (genvar w = 0; w < 2; w++) begin : g_way
    if (w < WAYS) begin : g_inst
      icache_way #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
      ) u_way (
        .clk        (clk),
        .rst        (rst),
        .clear_all  (flush),
        .rd_index   (rd_index),
        .rd_word    (rd_word),
        .rd_tag     (rd_tag),
        .hit        (way_hit[w]),
        .line_valid (way_valid[w]),
        .rd_data    (way_data[w]),
        .wr_en      (fill_we && (fill_way == 1'(w))),
        .wr_index   (fill_index),
        .wr_word    (fill_cnt),
        .wr_data    (bus_rdata),
        .wr_first   (fill_first),
        .wr_last    (fill_last),
        .wr_tag     (fill_tag)
      );
    end else begin : g_tie
      assign way_hit[w]   = 1'b0;
      assign way_valid[w] = 1'b1;
      assign way_data[w]  = '0;
    end
  end

  logic hit_any, hit, hit_way, victim;

  assign hit_any = |way_hit;
  assign hit     = rd_req && (state == IDLE) && hit_any;
  assign hit_way = way_hit[1];
  assign rd_wait = rd_req && !hit;
  assign rd_data = hit_way ? way_data[1] : way_data[0];

  // Prefer an empty way (way 0 first), otherwise evict the LRU way.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!way_valid[0])      victim = 1'b0;
      else if (!way_valid[1]) victim = 1'b1;
      else                    victim = lru[rd_index];
    end
  end

  // Next-state logic; flush both blocks a fill start and aborts a fill.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (rd_req && !hit_any && !flush) state_nx = FILL;
      FILL: if (flush || (fill_we && fill_last)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fill_cnt <= '0;
      lru      <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        fill_cnt <= '0;
        lru      <= '0;
      end else begin
        // Counter width equals log2(LINE_WORDS), so the last write wraps it.
        if (fill_we) fill_cnt <= fill_cnt + 1'b1;
        if (fill_we && fill_last) lru[fill_index] <= ~fill_way;
        else if (hit)             lru[rd_index]   <= ~hit_way;
      end
    end
  end

  // Miss capture: line address and victim are frozen for the whole fill so
  // later changes on rd_addr cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst && (state == IDLE) && (state_nx == FILL)) begin
      fill_line <= rd_addr[31:OB];
      fill_way  <= victim;
    end
  end

  assign bus_req   = (state == FILL);
  assign bus_rd    = bus_req && bus_ack;
  assign bus_addr  = bus_rd ? {fill_line, fill_cnt, 2'b00} : 32'h0;
  assign bus_wr    = 1'b0;
  assign bus_wdata = 32'h0;

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (SETS=16, LINE_WORDS=16, WAYS=2).
// The bus model returns ~address as the data for every word.
module tb_icache_assoc;

  logic        clk = 1'b0;
  logic        rst, rd_req, flush, bus_ack, bus_ready;
  logic [31:0] rd_addr;
  logic        rd_wait, bus_req, bus_rd, bus_wr;
  logic [31:0] rd_data, bus_addr, bus_rdata, bus_wdata;

  always #5 clk = ~clk;

  assign bus_rdata = ~bus_addr;

  icache_assoc #(.SETS(16), .LINE_WORDS(16), .WAYS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_req    (rd_req),
    .flush     (flush),
    .rd_wait   (rd_wait),
    .rd_data   (rd_data),
    .bus_req   (bus_req),
    .bus_ack   (bus_ack),
    .bus_addr  (bus_addr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_wdata (bus_wdata)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lookup without holding the request across an edge (no LRU change, no fill).
  task automatic probe(input string name, input logic [31:0] a, input bit exp_hit,
                       input logic [31:0] exp_data);
    rd_req  = 1'b1;
    rd_addr = a;
    #1;
    check({name, "_wait"}, rd_wait, !exp_hit);
    if (exp_hit) check({name, "_data"}, rd_data, exp_data);
    check({name, "_busreq"}, bus_req, 1'b0);
    rd_req = 1'b0;
    tick();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Holds a fetch until it is served, watching every bus read. The expected
  // bus address starts at a's line, steps one word per accepted beat, and
  // moves to a2's line after each complete line. Optionally switches rd_addr
  // to a2 after switch_after beats, or returns mid-fill after stop_after beats.
  int          f_writes, f_cycles, f_err;
  logic [31:0] f_data;

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] a2, input bit toggle,
                          input int switch_after, input int stop_after);
    logic [31:0] exp_addr;
    bit          done;
    exp_addr = {a[31:6], 6'b0};
    f_writes = 0;
    f_cycles = 0;
    f_err    = 0;
    f_data   = 32'h0;
    done     = 1'b0;
    rd_req   = 1'b1;
    rd_addr  = a;
    while (!done && f_cycles < 300) begin
      bus_ready = toggle ? (f_cycles % 2 == 0) : 1'b1;
      if (switch_after > 0 && f_writes == switch_after) rd_addr = a2;
      if (stop_after > 0 && f_writes == stop_after) return;
      #1;
      if (!rd_wait) begin
        done   = 1'b1;
        f_data = rd_data;
      end else begin
        if (bus_rd) begin
          if (bus_addr !== exp_addr) f_err++;
          if (bus_ready) begin
            f_writes++;
            exp_addr = (f_writes % 16 == 0) ? {a2[31:6], 6'b0} : exp_addr + 32'd4;
          end
        end
        @(posedge clk);
        #1;
        f_cycles++;
      end
    end
    check("fetch_served", done, 1'b1);
    // Keep the request through one more edge so the hit updates LRU.
    @(posedge clk);
    #1;
    rd_req    = 1'b0;
    bus_ready = 1'b1;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_1040, 1'b1, 32'hFFFF_EFBF};
    vecs[1]  = '{32'h0000_1044, 1'b1, 32'hFFFF_EFBB};
    vecs[2]  = '{32'h0000_1047, 1'b1, 32'hFFFF_EFBB};
    vecs[3]  = '{32'h0000_107C, 1'b1, 32'hFFFF_EF83};
    vecs[4]  = '{32'h0000_1440, 1'b1, 32'hFFFF_EBBF};
    vecs[5]  = '{32'h0000_145C, 1'b1, 32'hFFFF_EBA3};
    vecs[6]  = '{32'h0000_147C, 1'b1, 32'hFFFF_EB83};
    vecs[7]  = '{32'h0000_1840, 1'b0, 32'h0};
    vecs[8]  = '{32'h0000_1000, 1'b0, 32'h0};
    vecs[9]  = '{32'h0000_1080, 1'b0, 32'h0};
    vecs[10] = '{32'h0000_0040, 1'b0, 32'h0};

    rst       = 1'b1;
    rd_req    = 1'b1;
    rd_addr   = 32'h0000_1044;
    flush     = 1'b0;
    bus_ack   = 1'b1;
    bus_ready = 1'b1;
    tick();
    tick();
    #1;
    check("rst_rd_wait", rd_wait, 1'b1);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_rd", bus_rd, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wr", bus_wr, 1'b0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    rd_req = 1'b0;
    rst    = 1'b0;
    tick();
    probe("post_rst", 32'h0000_1044, 1'b0, 32'h0);

    // First miss: 16 reads of the line, served the cycle after the last.
    do_fetch(32'h0000_1044, 32'h0000_1044, 1'b0, 0, 0);
    check("f1044_writes", f_writes, 16);
    check("f1044_cycles", f_cycles, 17);
    check("f1044_addr_err", f_err, 0);
    check("f1044_data", f_data, 32'hFFFF_EFBB);

    // Same index, different tag: goes into the second way.
    do_fetch(32'h0000_1440, 32'h0000_1440, 1'b0, 0, 0);
    check("f1440_writes", f_writes, 16);
    check("f1440_cycles", f_cycles, 17);
    check("f1440_addr_err", f_err, 0);
    check("f1440_data", f_data, 32'hFFFF_EBBF);

    foreach (vecs[i]) probe($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hit, vecs[i].data);

    // Hit 0x1040 makes 0x1440 the LRU way; 0x1840 must evict it.
    do_fetch(32'h0000_1040, 32'h0000_1040, 1'b0, 0, 0);
    check("hit1040_cycles", f_cycles, 0);
    check("hit1040_data", f_data, 32'hFFFF_EFBF);
    do_fetch(32'h0000_1840, 32'h0000_1840, 1'b0, 0, 0);
    check("f1840_writes", f_writes, 16);
    check("f1840_addr_err", f_err, 0);
    probe("evicted1440", 32'h0000_1440, 1'b0, 32'h0);
    probe("kept1040", 32'h0000_1040, 1'b1, 32'hFFFF_EFBF);
    probe("new1840", 32'h0000_1840, 1'b1, 32'hFFFF_E7BF);

    // bus_ready alternating: beats only on ready cycles.
    do_fetch(32'h0000_3080, 32'h0000_3080, 1'b1, 0, 0);
    check("tog_writes", f_writes, 16);
    check("tog_cycles", f_cycles, 33);
    check("tog_addr_err", f_err, 0);
    check("tog_data", f_data, 32'hFFFF_CF7F);

    // Flush coinciding with a miss must not start a fill.
    rd_req  = 1'b1;
    rd_addr = 32'h0000_5040;
    flush   = 1'b1;
    tick();
    rd_req = 1'b0;
    flush  = 1'b0;
    #1;
    check("flush_blocks_fill", bus_req, 1'b0);
    tick();
    probe("flushed1040", 32'h0000_1040, 1'b0, 32'h0);

    // Address change mid-fill: 0x1040 line completes, then 0x2000 fills.
    do_fetch(32'h0000_1040, 32'h0000_2000, 1'b0, 5, 0);
    check("sw_writes", f_writes, 32);
    check("sw_cycles", f_cycles, 34);
    check("sw_addr_err", f_err, 0);
    check("sw_data", f_data, 32'hFFFF_DFFF);
    probe("sw_kept1040", 32'h0000_1040, 1'b1, 32'hFFFF_EFBF);
    probe("sw_2004", 32'h0000_2004, 1'b1, 32'hFFFF_DFFB);

    // Abort after 8 words by flush, then by reset; refill restarts cleanly.
    for (int k = 0; k < 2; k++) begin
      string nm;
      nm = (k == 0) ? "abort_flush" : "abort_rst";
      flush_pulse();
      do_fetch(32'h0000_1040, 32'h0000_1040, 1'b0, 0, 8);
      check({nm, "_partial"}, f_writes, 8);
      check({nm, "_partial_err"}, f_err, 0);
      rd_req = 1'b0;
      if (k == 0) flush = 1'b1;
      else        rst   = 1'b1;
      tick();
      flush = 1'b0;
      rst   = 1'b0;
      #1;
      check({nm, "_bus_req"}, bus_req, 1'b0);
      check({nm, "_bus_rd"}, bus_rd, 1'b0);
      tick();
      probe({nm, "_miss"}, 32'h0000_1040, 1'b0, 32'h0);
      do_fetch(32'h0000_1040, 32'h0000_1040, 1'b0, 0, 0);
      check({nm, "_refill_writes"}, f_writes, 16);
      check({nm, "_refill_err"}, f_err, 0);
      check({nm, "_refill_data"}, f_data, 32'hFFFF_EFBF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
